// File: rtl/rep_tx.sv
// Repetition-code transmitter: serialises a word LSB first and repeats each bit
// REP times so a majority-vote receiver can recover it.
module rep_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last
);

  localparam int CW = (REP > 1) ? $clog2(REP) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0]     chip_q, chip_d;
  logic [BW-1:0]     bit_q, bit_d;

  logic accept;
  logic advance;
  logic chip_end;
  logic word_end;

  // Handshakes: a word moves on in_valid && in_ready; a chip moves on
  // tx_valid && tx_ready. Both are evaluated at the rising edge only.
  always_comb begin
    accept   = (state_q == IDLE) && in_valid;
    advance  = (state_q == SEND) && tx_ready;
    chip_end = (chip_q == CHIP_LAST);
    word_end = chip_end && (bit_q == BIT_LAST);

    state_d = state_q;
    data_d  = data_q;
    chip_d  = chip_q;
    bit_d   = bit_q;

    if (accept) begin
      state_d = SEND;
      data_d  = in_data;
      chip_d  = '0;
      bit_d   = '0;
    end else if (advance) begin
      if (word_end) begin
        state_d = IDLE;
        chip_d  = '0;
        bit_d   = '0;
      end else if (chip_end) begin
        chip_d = '0;
        bit_d  = bit_q + 1'b1;
      end else begin
        chip_d = chip_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      chip_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      chip_q  <= chip_d;
      bit_q   <= bit_d;
    end
  end

  // Outputs decode registered state only, so stalls freeze them for free.
  assign in_ready = (state_q == IDLE);
  assign tx_valid = (state_q == SEND);
  assign tx_bit   = tx_valid && data_q[bit_q];
  assign tx_first = tx_valid && (chip_q == '0);
  assign tx_last  = tx_valid && word_end;

endmodule
